// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap controller with a clock-enabled seconds/minutes
// engine derived from a single system clock.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic [5:0] secs,
    output logic [5:0] mins,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       running,
    output logic       lapped,
    output logic [1:0] state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [5:0]    SEC_LAST = 6'(SEC_MAX);
    localparam logic [5:0]    MIN_LAST = 6'(MIN_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t        st_q, st_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    lsec_q, lsec_d;
    logic [5:0]    lmin_q, lmin_d;
    logic [5:0]    secs_d, mins_d;
    logic          cnt_en, tick, sec_wrap;

    // A start_stop seen while counting stops the count on that same edge.
    assign cnt_en = (st_q == S_RUN || st_q == S_LAP) && !start_stop;

    always_comb begin
        st_d     = st_q;
        pre_d    = pre_q;
        sec_d    = sec_q;
        min_d    = min_q;
        lsec_d   = lsec_q;
        lmin_d   = lmin_q;
        tick     = 1'b0;
        sec_wrap = 1'b0;

        if (cnt_en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        if (tick) begin
            if (sec_q == SEC_LAST) begin
                sec_d    = '0;
                sec_wrap = 1'b1;
                min_d    = (min_q == MIN_LAST) ? 6'd0 : min_q + 6'd1;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        unique case (st_q)
            S_IDLE: begin
                if (start_stop) st_d = S_RUN;
            end
            S_RUN: begin
                if (start_stop) begin
                    st_d = S_PAUSE;
                end else if (lap_reset) begin
                    st_d   = S_LAP;
                    lsec_d = sec_d;
                    lmin_d = min_d;
                end
            end
            S_LAP: begin
                if (start_stop)     st_d = S_PAUSE;
                else if (lap_reset) st_d = S_RUN;
            end
            S_PAUSE: begin
                if (start_stop) begin
                    st_d = S_RUN;
                end else if (lap_reset) begin
                    st_d   = S_IDLE;
                    pre_d  = '0;
                    sec_d  = '0;
                    min_d  = '0;
                    lsec_d = '0;
                    lmin_d = '0;
                end
            end
            default: st_d = S_IDLE;
        endcase

        secs_d = (st_d == S_LAP) ? lsec_d : sec_d;
        mins_d = (st_d == S_LAP) ? lmin_d : min_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= S_IDLE;
            pre_q    <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            lsec_q   <= '0;
            lmin_q   <= '0;
            secs     <= '0;
            mins     <= '0;
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
        end else begin
            st_q     <= st_d;
            pre_q    <= pre_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            lsec_q   <= lsec_d;
            lmin_q   <= lmin_d;
            secs     <= secs_d;
            mins     <= mins_d;
            sec_tick <= tick;
            min_tick <= sec_wrap;
        end
    end

    assign state   = st_q;
    assign running = (st_q == S_RUN) || (st_q == S_LAP);
    assign lapped  = (st_q == S_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: directed scenarios plus random button
// traffic, checked every cycle against an elapsed-time reference model.
module tb_stopwatch_ctrl;

    localparam int TD   = 4;
    localparam int SMAX = 59;
    localparam int MMAX = 59;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap_reset = 1'b0;
    logic [5:0] secs, mins;
    logic       sec_tick, min_tick, running, lapped;
    logic [1:0] state;

    stopwatch_ctrl #(
        .TICK_DIV(TD),
        .SEC_MAX (SMAX),
        .MIN_MAX (MMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .lap_reset (lap_reset),
        .secs      (secs),
        .mins      (mins),
        .sec_tick  (sec_tick),
        .min_tick  (min_tick),
        .running   (running),
        .lapped    (lapped),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] secs;
        logic [5:0] mins;
        logic       st;
        logic       mt;
        logic       run;
        logic       lap;
        logic [1:0] state;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: elapsed counted cycles, converted to time on demand.
    int m_state = 0;
    int m_counted = 0;
    int m_lap = 0;

    task automatic step(input logic r, input logic ss, input logic lr);
        obs_t e;
        int   shown;
        bit   tk, mtk, counting;
        @(negedge clk);
        rst        = r;
        start_stop = ss;
        lap_reset  = lr;
        tk  = 0;
        mtk = 0;
        if (r) begin
            m_state   = 0;
            m_counted = 0;
            m_lap     = 0;
        end else begin
            counting = (m_state == 1 || m_state == 3) && !ss;
            if (counting) begin
                m_counted++;
                tk  = (m_counted % TD) == 0;
                mtk = tk && ((m_counted / TD) % (SMAX + 1)) == 0;
            end
            case (m_state)
                0: if (ss) m_state = 1;
                1: if (ss) m_state = 2;
                   else if (lr) begin
                       m_state = 3;
                       m_lap   = m_counted / TD;
                   end
                3: if (ss) m_state = 2;
                   else if (lr) m_state = 1;
                2: if (ss) m_state = 1;
                   else if (lr) begin
                       m_state   = 0;
                       m_counted = 0;
                       m_lap     = 0;
                   end
                default: m_state = 0;
            endcase
        end
        shown   = (m_state == 3) ? m_lap : m_counted / TD;
        e.secs  = 6'(shown % (SMAX + 1));
        e.mins  = 6'((shown / (SMAX + 1)) % (MMAX + 1));
        e.st    = tk;
        e.mt    = mtk;
        e.run   = (m_state == 1 || m_state == 3);
        e.lap   = (m_state == 3);
        e.state = 2'(m_state);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{secs, mins, sec_tick, min_tick, running, lapped, state};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL cyc%0d got %0d:%0d st=%b mt=%b run=%b lap=%b state=%0d want %0d:%0d st=%b mt=%b run=%b lap=%b state=%0d",
                             cyc, a.mins, a.secs, a.st, a.mt, a.run, a.lap, a.state,
                             e.mins, e.secs, e.st, e.mt, e.run, e.lap, e.state);
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : driver
        // Reset and idle: lap_reset ignored in IDLE
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        idle(20);

        // Full run through 0:59->1:00 and 59:59->00:00
        step(0, 1, 0);
        idle(3600 * TD + 6);

        // Pause at pre=2, resume finishes the partial second
        step(1, 0, 0);
        step(0, 1, 0);
        idle(2);
        step(0, 1, 0);
        idle(10);
        step(0, 1, 0);
        idle(8);

        // Lap freeze at 0:05, three ticks underneath, release at 0:08
        step(1, 0, 0);
        step(0, 1, 0);
        idle(5 * TD);
        step(0, 0, 1);
        idle(3 * TD);
        step(0, 0, 1);
        idle(3);

        // Pause at 0:07 (approx), both buttons -> RUN, then clear
        step(1, 0, 0);
        step(0, 1, 0);
        idle(7 * TD);
        step(0, 1, 0);
        idle(3);
        step(0, 1, 1);
        idle(5);
        step(0, 1, 0);
        step(0, 0, 1);
        idle(6);

        // Mid-run reset while in LAP at 1:23, then restart from 0:00
        step(0, 1, 0);
        idle(83 * TD);
        step(0, 0, 1);
        idle(2);
        step(1, 0, 0);
        idle(3);
        step(0, 1, 0);
        idle(2 * TD + 2);

        // Random button traffic, occasional reset
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 11) == 0));
        end

        @(negedge clk);
        rst        = 0;
        start_stop = 0;
        lap_reset  = 0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
